// File: rtl/mcu_uart_pkg.sv
// Shared types and constants for the MCU UART transmit path.
package mcu_uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   localparam int unsigned UART_DATA_BITS   = 8;
   localparam int unsigned UART_FRAME_BITS  = 10;
   localparam int unsigned DEFAULT_BAUD_DIV = 217;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/clear. The registered level is the only full/empty source;
// pointers simply wrap because DEPTH is a power of two.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     clear,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push_ok, pop_ok;

   // A clear in the same cycle wins over both push and pop.
   assign push_ok = push & (level_q != FULL_LVL) & ~clear;
   assign pop_ok  = pop & (level_q != '0) & ~clear;

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;

   // Next-state for pointers and level.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_ok && !pop_ok) level_d = level_q + 1'b1;
         if (pop_ok && !push_ok) level_d = level_q - 1'b1;
      end
   end

   // Pointer and level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes are queued in a small FIFO and serialised LSB-first.
module uart_tx_fifo
   import mcu_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          wr_valid,
   input  logic [7:0]                    wr_data,
   output logic                          wr_ready,
   input  logic                          tx_enable,
   input  logic                          fifo_clear,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          tx_busy,
   output logic                          uart_tx_output
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
   localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t state_q, state_d;
   logic [15:0]    baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           tx_q, tx_d;
   logic           busy_q, busy_d;

   logic           push, pop, can_start, baud_end;
   logic [7:0]     fifo_rdata;

   // Full blocks writes even if a pop happens in the same cycle; clear blocks them too.
   assign wr_ready = (fifo_level != FULL_LVL) & ~fifo_clear;
   assign push     = wr_valid & wr_ready;

   // A pending clear flushes the queue, so never start a frame from it in that cycle.
   assign can_start = tx_enable & (fifo_level != '0) & ~fifo_clear;
   assign baud_end  = (baud_q == BAUD_LAST);

   assign tx_busy        = busy_q;
   assign uart_tx_output = tx_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clock),
      .rst_n (reset_n),
      .push  (push),
      .wdata (wr_data),
      .pop   (pop),
      .clear (fifo_clear),
      .rdata (fifo_rdata),
      .level (fifo_level)
   );

   // Frame sequencing: next state, baud/bit counters, shift register and line level.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (can_start) begin
               pop     = 1'b1;
               shift_d = fifo_rdata;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == LAST_BIT) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (can_start) begin
                  // Back-to-back frame: go straight to START with no idle gap.
                  pop     = 1'b1;
                  shift_d = fifo_rdata;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            baud_d  = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Transmit state registers; reset returns the line high immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule
